// File: rtl/syn_fifo_if.sv
// rtl/syn_fifo_if.sv - write/read handshake and status bundle for syn_fifo
interface syn_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  // Producer/consumer side: drives requests, observes data and status
  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/syn_fifo.sv
// rtl/syn_fifo.sv - single-clock FIFO with standard/FWFT read, fill count and thresholds
module syn_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input logic       clk,
  input logic       rst,
  syn_fifo_if.slave bus
);

  localparam int DATA_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status flags decode only the registered count, so they never follow wr_en/rd_en combinationally
  assign bus.count        = count_q;
  assign bus.full         = (count_q == DEPTH_C);
  assign bus.empty        = (count_q == '0);
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // A full FIFO still accepts a read and an empty FIFO still accepts a write,
  // which gives the simultaneous-request priorities without extra terms
  assign wr_acc = bus.wr_en & ~bus.full;
  assign rd_acc = bus.rd_en & ~bus.empty;

  // Storage is never reset; stale contents are unreachable once the pointers clear
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
  end

  // Pointers, fill count and one-cycle error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      if (wr_acc && !rd_acc)      count_q <= count_q + ONE;
      else if (!wr_acc && rd_acc) count_q <= count_q - ONE;
      overflow_q  <= bus.wr_en & bus.full;
      underflow_q <= bus.rd_en & bus.empty;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented straight from the registered read pointer; rd_en only pops
      assign bus.data_out = mem[rd_ptr[ADDR_WIDTH-1:0]];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;

      // Output register loads the head word on an accepted read and otherwise holds
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end

      assign bus.data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_syn_fifo.sv
// tb/tb_syn_fifo.sv - directed self-checking bench for syn_fifo in standard and FWFT modes
module tb_syn_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  syn_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ifa ();
  syn_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ifb ();

  syn_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b0)) u_std (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  syn_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b1),
             .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.data_in = '0; ifa.wr_en = 1'b0; ifa.rd_en = 1'b0;
    ifb.data_in = '0; ifb.wr_en = 1'b0; ifb.rd_en = 1'b0;

    // reset state
    #12;
    chk("rst_empty", ifa.empty, 1);
    chk("rst_full", ifa.full, 0);
    chk("rst_afull", ifa.almost_full, 0);
    chk("rst_aempty", ifa.almost_empty, 1);
    chk("rst_count", ifa.count, 0);
    chk("rst_dout", ifa.data_out, 0);
    chk("rst_ovf", ifa.overflow, 0);
    chk("rst_unf", ifa.underflow, 0);
    tick();
    rst = 1'b0;

    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      ifa.wr_en = 1'b1; ifa.data_in = 8'(i);
      tick();
      chk($sformatf("fill_count%0d", i), ifa.count, i + 1);
      chk($sformatf("fill_afull%0d", i), ifa.almost_full, (i + 1 >= 14) ? 1 : 0);
      chk($sformatf("fill_full%0d", i), ifa.full, (i + 1 == 16) ? 1 : 0);
      chk($sformatf("fill_empty%0d", i), ifa.empty, 0);
    end
    ifa.data_in = 8'hAA;
    tick();
    chk("ovf_pulse", ifa.overflow, 1);
    chk("ovf_count", ifa.count, 16);
    ifa.wr_en = 1'b0;
    tick();
    chk("ovf_clear", ifa.overflow, 0);

    // drain in standard mode
    for (int i = 0; i < 16; i++) begin
      ifa.rd_en = 1'b1;
      tick();
      chk($sformatf("drain_dout%0d", i), ifa.data_out, i);
      chk($sformatf("drain_count%0d", i), ifa.count, 15 - i);
      chk($sformatf("drain_empty%0d", i), ifa.empty, (i == 15) ? 1 : 0);
    end
    tick();
    chk("unf_pulse1", ifa.underflow, 1);
    chk("unf_hold_dout", ifa.data_out, 8'h0F);
    tick();
    chk("unf_pulse2", ifa.underflow, 1);
    ifa.rd_en = 1'b0;
    tick();
    chk("unf_clear", ifa.underflow, 0);
    chk("unf_count", ifa.count, 0);

    // simultaneous read/write at count 8 across pointer wrap
    for (int i = 0; i < 8; i++) begin
      ifa.wr_en = 1'b1; ifa.data_in = 8'(8'h10 + i);
      tick();
    end
    chk("sim_pre_count", ifa.count, 8);
    for (int i = 0; i < 20; i++) begin
      ifa.wr_en = 1'b1; ifa.rd_en = 1'b1; ifa.data_in = 8'(8'h18 + i);
      tick();
      chk($sformatf("sim_count%0d", i), ifa.count, 8);
      chk($sformatf("sim_dout%0d", i), ifa.data_out, 8'h10 + i);
    end
    ifa.wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("sim_tail%0d", i), ifa.data_out, 8'h24 + i);
    end
    ifa.rd_en = 1'b0;
    tick();
    chk("sim_end_empty", ifa.empty, 1);

    // simultaneous when full: read only, overflow pulses
    for (int i = 0; i < 16; i++) begin
      ifa.wr_en = 1'b1; ifa.data_in = 8'(8'h40 + i);
      tick();
    end
    chk("fullsim_pre_full", ifa.full, 1);
    ifa.rd_en = 1'b1; ifa.data_in = 8'hEE;
    tick();
    chk("fullsim_count", ifa.count, 15);
    chk("fullsim_ovf", ifa.overflow, 1);
    chk("fullsim_dout", ifa.data_out, 8'h40);
    chk("fullsim_full", ifa.full, 0);
    ifa.wr_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("fullsim_drain%0d", i), ifa.data_out, 8'h41 + i);
    end
    chk("fullsim_ovf_clear", ifa.overflow, 0);
    chk("fullsim_empty", ifa.empty, 1);

    // simultaneous when empty: write only, underflow pulses
    ifa.wr_en = 1'b1; ifa.rd_en = 1'b1; ifa.data_in = 8'h77;
    tick();
    chk("emptysim_count", ifa.count, 1);
    chk("emptysim_unf", ifa.underflow, 1);
    chk("emptysim_dout_hold", ifa.data_out, 8'h4F);
    ifa.wr_en = 1'b0;
    tick();
    chk("emptysim_read", ifa.data_out, 8'h77);
    chk("emptysim_count0", ifa.count, 0);
    ifa.rd_en = 1'b0;

    // asynchronous reset mid-burst at count 9
    for (int i = 0; i < 9; i++) begin
      ifa.wr_en = 1'b1; ifa.data_in = 8'(8'h90 + i);
      tick();
    end
    ifa.wr_en = 1'b0;
    chk("arst_pre_count", ifa.count, 9);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", ifa.count, 0);
    chk("arst_empty", ifa.empty, 1);
    chk("arst_aempty", ifa.almost_empty, 1);
    chk("arst_full", ifa.full, 0);
    chk("arst_afull", ifa.almost_full, 0);
    chk("arst_dout", ifa.data_out, 0);
    tick();
    rst = 1'b0;
    ifa.wr_en = 1'b1; ifa.data_in = 8'h33;
    tick();
    ifa.wr_en = 1'b0; ifa.rd_en = 1'b1;
    tick();
    ifa.rd_en = 1'b0;
    chk("arst_fresh_dout", ifa.data_out, 8'h33);
    chk("arst_fresh_count", ifa.count, 0);

    // FWFT instance with thresholds 4/1
    chk("fw_rst_empty", ifb.empty, 1);
    chk("fw_rst_aempty", ifb.almost_empty, 1);
    ifb.wr_en = 1'b1; ifb.data_in = 8'h5A;
    tick();
    ifb.wr_en = 1'b0;
    chk("fw_empty_fall", ifb.empty, 0);
    chk("fw_head", ifb.data_out, 8'h5A);
    chk("fw_count1", ifb.count, 1);
    tick();
    chk("fw_head_hold", ifb.data_out, 8'h5A);
    ifb.rd_en = 1'b1;
    tick();
    ifb.rd_en = 1'b0;
    chk("fw_pop_empty", ifb.empty, 1);
    chk("fw_pop_count", ifb.count, 0);

    for (int i = 0; i < 4; i++) begin
      ifb.wr_en = 1'b1; ifb.data_in = 8'(8'h01 + i);
      tick();
      chk($sformatf("fw_thr_aempty%0d", i), ifb.almost_empty, (i + 1 <= 1) ? 1 : 0);
      chk($sformatf("fw_thr_afull%0d", i), ifb.almost_full, (i + 1 >= 4) ? 1 : 0);
      chk($sformatf("fw_thr_head%0d", i), ifb.data_out, 8'h01);
    end
    ifb.wr_en = 1'b0; ifb.rd_en = 1'b1;
    tick();
    ifb.rd_en = 1'b0;
    chk("fw_next_head", ifb.data_out, 8'h02);
    chk("fw_afull_drop", ifb.almost_full, 0);
    chk("fw_count3", ifb.count, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
